// File: rtl/lutram_bist_ctrl.sv
// BIST sequencer for one 64x1 dual-port LUTRAM: CLEAR background, WRITE pattern,
// READ both ports (SPO at addr, DPO at ~addr), count mismatches and report the result.
module lutram_bist_ctrl #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 0,
    parameter int ERR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic              ram_we_o,
    output logic              ram_d_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [ADDR_W-1:0] ram_dpra_o,
    input  logic              ram_spo_i,
    input  logic              ram_dpo_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [DW-1:0]     DRAIN_ONE  = DW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        pat_q, pat_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              seen_q, seen_d;
    logic              clrCnt;

    logic              readEn;
    logic              expSpo;
    logic              expDpo;
    logic              cmpVld;
    logic              cmpExpSpo;
    logic              cmpExpDpo;
    logic [ADDR_W-1:0] cmpAddr;
    logic              spoMis;
    logic              dpoMis;
    logic [ERR_W:0]    errSum;

    function automatic logic patBit(input logic [1:0] p, input logic lsb);
        case (p)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return lsb;
            default: return ~lsb;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pat_d   = pat_q;
        drain_d = drain_q;
        clrCnt  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pat_d   = pattern_i;
                    addr_d  = '0;
                    clrCnt  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                addr_d = addr_q + ADDR_ONE;
                if (&addr_q) state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_ONE;
                if (&addr_q) state_d = S_READ;
            end
            S_READ: begin
                addr_d = addr_q + ADDR_ONE;
                if (&addr_q) begin
                    drain_d = '0;
                    state_d = (RD_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DRAIN_ONE;
                if (drain_q == DRAIN_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign readEn = (state_q == S_READ);
    assign expSpo = patBit(pat_q, addr_q[0]);
    assign expDpo = patBit(pat_q, ~addr_q[0]);

    // Expected bits travel alongside the read so they line up with a registered RAM output;
    // the DPO address is always the complement of the SPO address, so only one is carried.
    generate
        if (RD_LAT == 0) begin : g_async
            assign cmpVld    = readEn;
            assign cmpExpSpo = expSpo;
            assign cmpExpDpo = expDpo;
            assign cmpAddr   = addr_q;
        end else begin : g_pipe
            logic [RD_LAT-1:0] vld_q;
            logic [RD_LAT-1:0] spo_q;
            logic [RD_LAT-1:0] dpo_q;
            logic [ADDR_W-1:0] adr_q [RD_LAT];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    spo_q <= '0;
                    dpo_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
                end else begin
                    vld_q[0] <= readEn;
                    spo_q[0] <= expSpo;
                    dpo_q[0] <= expDpo;
                    adr_q[0] <= addr_q;
                    for (int i = 1; i < RD_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        spo_q[i] <= spo_q[i-1];
                        dpo_q[i] <= dpo_q[i-1];
                        adr_q[i] <= adr_q[i-1];
                    end
                end
            end

            assign cmpVld    = vld_q[RD_LAT-1];
            assign cmpExpSpo = spo_q[RD_LAT-1];
            assign cmpExpDpo = dpo_q[RD_LAT-1];
            assign cmpAddr   = adr_q[RD_LAT-1];
        end
    endgenerate

    assign spoMis = cmpVld & (ram_spo_i ^ cmpExpSpo);
    assign dpoMis = cmpVld & (ram_dpo_i ^ cmpExpDpo);
    assign errSum = {1'b0, err_q} + (ERR_W+1)'(spoMis) + (ERR_W+1)'(dpoMis);

    // At most two are added per cycle, so the carry bit alone flags overflow.
    always_comb begin
        err_d   = errSum[ERR_W] ? ERR_MAX : errSum[ERR_W-1:0];
        first_d = first_q;
        seen_d  = seen_q;
        if (!seen_q && (spoMis || dpoMis)) begin
            first_d = spoMis ? cmpAddr : ~cmpAddr;
            seen_d  = 1'b1;
        end
        if (clrCnt) begin
            err_d   = '0;
            first_d = '0;
            seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pat_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        busy_o           = (state_q == S_CLEAR) || (state_q == S_WRITE) ||
                           (state_q == S_READ)  || (state_q == S_DRAIN);
        done_o           = (state_q == S_DONE);
        pass_o           = (state_q == S_DONE) && (err_q == '0);
        err_count_o      = err_q;
        first_err_addr_o = first_q;
        ram_we_o         = 1'b0;
        ram_d_o          = 1'b0;
        ram_a_o          = '0;
        ram_dpra_o       = '0;
        case (state_q)
            S_CLEAR: begin
                ram_we_o   = 1'b1;
                ram_d_o    = ~expSpo;
                ram_a_o    = addr_q;
                ram_dpra_o = addr_q;
            end
            S_WRITE: begin
                ram_we_o   = 1'b1;
                ram_d_o    = expSpo;
                ram_a_o    = addr_q;
                ram_dpra_o = addr_q;
            end
            S_READ: begin
                ram_a_o    = addr_q;
                ram_dpra_o = ~addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lutram_bist_ctrl.sv
// Directed bench for lutram_bist_ctrl: an async-read RAM model (RD_LAT=0, ERR_W=6)
// and a registered-read RAM model (RD_LAT=1, ERR_W=8), each with injectable stuck-at-0 faults.
module tb_lutram_bist_ctrl;

    logic clk;
    logic rstN;

    logic       startA, startB;
    logic [1:0] patA, patB;
    logic       busyA, doneA, passA, weA, dA, spoA, dpoA;
    logic       busyB, doneB, passB, weB, dB, spoB, dpoB;
    logic [5:0] errA, firstA, aA, dpraA;
    logic [7:0] errB;
    logic [5:0] firstB, aB, dpraB;

    logic [63:0] memA, memB;
    logic        stuckAllA, stuckOneA, stuckOneB;
    logic [5:0]  stuckAdrA, stuckAdrB;

    int checks = 0;
    int errors = 0;

    lutram_bist_ctrl #(.ADDR_W(6), .RD_LAT(0), .ERR_W(6)) dutA (
        .clk_i(clk), .rst_ni(rstN), .start_i(startA), .pattern_i(patA),
        .busy_o(busyA), .done_o(doneA), .pass_o(passA), .err_count_o(errA),
        .first_err_addr_o(firstA), .ram_we_o(weA), .ram_d_o(dA), .ram_a_o(aA),
        .ram_dpra_o(dpraA), .ram_spo_i(spoA), .ram_dpo_i(dpoA)
    );

    lutram_bist_ctrl #(.ADDR_W(6), .RD_LAT(1), .ERR_W(8)) dutB (
        .clk_i(clk), .rst_ni(rstN), .start_i(startB), .pattern_i(patB),
        .busy_o(busyB), .done_o(doneB), .pass_o(passB), .err_count_o(errB),
        .first_err_addr_o(firstB), .ram_we_o(weB), .ram_d_o(dB), .ram_a_o(aB),
        .ram_dpra_o(dpraB), .ram_spo_i(spoB), .ram_dpo_i(dpoB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic readCell(input logic [63:0] mem, input logic [5:0] adr,
                                      input logic stuckAll, input logic stuckOne,
                                      input logic [5:0] stuckAdr);
        if (stuckAll || (stuckOne && adr == stuckAdr)) return 1'b0;
        return mem[adr];
    endfunction

    // Async-read RAM: writes on the clock, reads follow the address combinationally.
    always @(posedge clk) if (weA) memA[aA] <= dA;
    always_comb begin
        spoA = readCell(memA, aA, stuckAllA, stuckOneA, stuckAdrA);
        dpoA = readCell(memA, dpraA, stuckAllA, stuckOneA, stuckAdrA);
    end

    // Registered-read RAM: read data appears one clock after the address.
    always @(posedge clk) begin
        if (weB) memB[aB] <= dB;
        spoB <= readCell(memB, aB, 1'b0, stuckOneB, stuckAdrB);
        dpoB <= readCell(memB, dpraB, 1'b0, stuckOneB, stuckAdrB);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulses start on the chosen DUT; returns in cycle 1 of the new run.
    task automatic applyStimulus(input int sel, input logic [1:0] pat);
        if (sel == 0) begin startA = 1'b1; patA = pat; end
        else          begin startB = 1'b1; patB = pat; end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
    endtask

    initial begin
        rstN = 1'b0;
        startA = 1'b0; startB = 1'b0;
        patA = 2'b00;  patB = 2'b00;
        stuckAllA = 1'b0; stuckOneA = 1'b0; stuckOneB = 1'b0;
        stuckAdrA = 6'd5; stuckAdrB = 6'd5;

        waitCycles(2);
        checkOutput("rst_busy",  32'(busyA), 0);
        checkOutput("rst_done",  32'(doneA), 0);
        checkOutput("rst_pass",  32'(passA), 0);
        checkOutput("rst_err",   32'(errA), 0);
        checkOutput("rst_we",    32'(weA), 0);
        checkOutput("rst_dpra",  32'(dpraA), 0);
        rstN = 1'b1;
        waitCycles(1);

        $display("[TB] ideal RAM, checker pattern");
        applyStimulus(0, 2'b10);
        checkOutput("s1_c1_busy", 32'(busyA), 1);
        checkOutput("s1_c1_we",   32'(weA), 1);
        checkOutput("s1_c1_a",    32'(aA), 0);
        checkOutput("s1_c1_d",    32'(dA), 1);
        waitCycles(1);
        checkOutput("s1_c2_a",    32'(aA), 1);
        checkOutput("s1_c2_d",    32'(dA), 0);
        waitCycles(63);
        checkOutput("s1_c65_we",  32'(weA), 1);
        checkOutput("s1_c65_a",   32'(aA), 0);
        checkOutput("s1_c65_d",   32'(dA), 0);
        waitCycles(1);
        checkOutput("s1_c66_d",   32'(dA), 1);
        waitCycles(63);
        checkOutput("s1_c129_we",   32'(weA), 0);
        checkOutput("s1_c129_a",    32'(aA), 0);
        checkOutput("s1_c129_dpra", 32'(dpraA), 63);
        waitCycles(63);
        checkOutput("s1_c192_done", 32'(doneA), 0);
        waitCycles(1);
        checkOutput("s1_c193_done", 32'(doneA), 1);
        checkOutput("s1_c193_busy", 32'(busyA), 0);
        checkOutput("s1_c193_pass", 32'(passA), 1);
        checkOutput("s1_c193_err",  32'(errA), 0);
        checkOutput("s1_c193_a",    32'(aA), 0);

        $display("[TB] start and pattern change while busy");
        applyStimulus(0, 2'b10);
        waitCycles(49);
        startA = 1'b1;
        patA = 2'b01;
        waitCycles(1);
        startA = 1'b0;
        checkOutput("s5_c51_a", 32'(aA), 50);
        checkOutput("s5_c51_d", 32'(dA), 1);
        waitCycles(142);
        checkOutput("s5_done", 32'(doneA), 1);
        checkOutput("s5_pass", 32'(passA), 1);
        checkOutput("s5_err",  32'(errA), 0);

        $display("[TB] stuck-at-0 at address 5");
        stuckOneA = 1'b1;
        applyStimulus(0, 2'b01);
        checkOutput("s2_c1_done", 32'(doneA), 0);
        waitCycles(133);
        checkOutput("s2_c134_err",   32'(errA), 0);
        waitCycles(1);
        checkOutput("s2_c135_err",   32'(errA), 1);
        checkOutput("s2_c135_first", 32'(firstA), 5);
        waitCycles(58);
        checkOutput("s2_done",  32'(doneA), 1);
        checkOutput("s2_err",   32'(errA), 2);
        checkOutput("s2_first", 32'(firstA), 5);
        checkOutput("s2_pass",  32'(passA), 0);

        $display("[TB] whole RAM stuck-at-0, saturation");
        stuckOneA = 1'b0;
        stuckAllA = 1'b1;
        applyStimulus(0, 2'b01);
        waitCycles(159);
        checkOutput("s3_c160_err", 32'(errA), 62);
        waitCycles(1);
        checkOutput("s3_c161_err", 32'(errA), 63);
        waitCycles(32);
        checkOutput("s3_err",   32'(errA), 63);
        checkOutput("s3_first", 32'(firstA), 0);
        checkOutput("s3_pass",  32'(passA), 0);

        $display("[TB] restart from DONE, then reset during READ");
        stuckAllA = 1'b0;
        applyStimulus(0, 2'b10);
        checkOutput("rs_done", 32'(doneA), 0);
        checkOutput("rs_busy", 32'(busyA), 1);
        checkOutput("rs_err",  32'(errA), 0);
        waitCycles(149);
        checkOutput("s6_c150_dpra", 32'(dpraA), 42);
        rstN = 1'b0;
        #1;
        checkOutput("s6_rst_busy", 32'(busyA), 0);
        checkOutput("s6_rst_a",    32'(aA), 0);
        checkOutput("s6_rst_dpra", 32'(dpraA), 0);
        checkOutput("s6_rst_done", 32'(doneA), 0);
        waitCycles(1);
        rstN = 1'b1;
        waitCycles(1);
        applyStimulus(0, 2'b10);
        waitCycles(192);
        checkOutput("s6_done", 32'(doneA), 1);
        checkOutput("s6_pass", 32'(passA), 1);
        checkOutput("s6_err",  32'(errA), 0);

        $display("[TB] registered RAM, RD_LAT=1");
        applyStimulus(1, 2'b11);
        waitCycles(192);
        checkOutput("s4_c193_done", 32'(doneB), 0);
        checkOutput("s4_c193_busy", 32'(busyB), 1);
        waitCycles(1);
        checkOutput("s4_c194_done", 32'(doneB), 1);
        checkOutput("s4_pass",      32'(passB), 1);
        checkOutput("s4_err",       32'(errB), 0);

        stuckOneB = 1'b1;
        applyStimulus(1, 2'b01);
        checkOutput("s4f_c1_done", 32'(doneB), 0);
        waitCycles(134);
        checkOutput("s4f_c135_err", 32'(errB), 0);
        waitCycles(1);
        checkOutput("s4f_c136_err", 32'(errB), 1);
        waitCycles(58);
        checkOutput("s4f_done",  32'(doneB), 1);
        checkOutput("s4f_err",   32'(errB), 2);
        checkOutput("s4f_first", 32'(firstB), 5);
        checkOutput("s4f_pass",  32'(passB), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
